// File: rtl/sbox_share_scheduler.sv
// Streams one 128-bit state through NUM_SBOX shared, fixed-latency S-box lanes,
// one group of bytes per fresh-randomness cycle, and reassembles the substituted state.
module sbox_share_scheduler #(
    parameter int NUM_SBOX = 4,
    parameter int SBOX_LAT = 2,
    parameter int RND_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              in_state,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              out_state,
    output logic                      sbox_vld,
    output logic [8*NUM_SBOX-1:0]     sbox_din,
    output logic [RND_W*NUM_SBOX-1:0] sbox_rnd,
    input  logic [8*NUM_SBOX-1:0]     sbox_dout,
    input  logic                      rnd_valid,
    input  logic [RND_W*NUM_SBOX-1:0] rnd_data,
    output logic                      rnd_ack,
    output logic                      busy
);
    localparam int         LW       = 8 * NUM_SBOX;
    localparam int         RW       = RND_W * NUM_SBOX;
    localparam int         SH       = $clog2(LW);
    localparam logic [3:0] GRP_LAST = 4'(16 / NUM_SBOX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   fsm_r;
    state_t                   fsm_nxt_s;
    logic [127:0]             data_r;
    logic [127:0]             result_r;
    logic [3:0]               grp_r;
    logic [SBOX_LAT-1:0]      tag_vld_r;
    logic [SBOX_LAT-1:0][3:0] tag_grp_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     busy_r;
    logic                     issue_s;
    logic                     accept_s;
    logic                     pend_s;
    logic [6:0]               din_base_s;
    logic [6:0]               cap_base_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign out_state  = result_r;
    assign sbox_vld   = issue_s;
    assign rnd_ack    = issue_s;
    assign din_base_s = 7'(grp_r) << SH;
    assign cap_base_s = 7'(tag_grp_r[SBOX_LAT-1]) << SH;

    // Pending results other than the one retiring this cycle; the last stage is
    // captured on the same edge that leaves DRAIN.
    always_comb begin
        pend_s = 1'b0;
        for (int i = 0; i < SBOX_LAT - 1; i++) begin
            pend_s = pend_s | tag_vld_r[i];
        end
    end

    // Next-state logic; flush overrides every transition including an accept.
    always_comb begin
        fsm_nxt_s = fsm_r;
        issue_s   = (fsm_r == FEED) && rnd_valid;
        accept_s  = (fsm_r == IDLE) && in_valid && !flush;
        if (flush) begin
            fsm_nxt_s = IDLE;
        end else begin
            case (fsm_r)
                IDLE:    fsm_nxt_s = in_valid ? FEED : IDLE;
                FEED:    fsm_nxt_s = (rnd_valid && (grp_r == GRP_LAST)) ? DRAIN : FEED;
                DRAIN:   fsm_nxt_s = pend_s ? DRAIN : DONE;
                DONE:    fsm_nxt_s = out_ready ? IDLE : DONE;
                default: fsm_nxt_s = IDLE;
            endcase
        end
    end

    // Lane drive; mask bits are only forwarded on a real issue so nothing is reused.
    always_comb begin
        sbox_din = {LW{1'b0}};
        sbox_rnd = {RW{1'b0}};
        if (issue_s) begin
            sbox_din = data_r[din_base_s +: LW];
            sbox_rnd = rnd_data;
        end else begin
            sbox_din = {LW{1'b0}};
            sbox_rnd = {RW{1'b0}};
        end
    end

    // Control state, handshake flags and group counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= IDLE;
            grp_r       <= 4'd0;
            data_r      <= 128'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_nxt_s;
            in_ready_r  <= (fsm_nxt_s == IDLE);
            out_valid_r <= (fsm_nxt_s == DONE);
            busy_r      <= (fsm_nxt_s != IDLE);
            if (accept_s) begin
                data_r <= in_state;
            end
            if (flush || accept_s) begin
                grp_r <= 4'd0;
            end else if (issue_s) begin
                grp_r <= grp_r + 4'd1;
            end
        end
    end

    // Tag pipe mirrors the lane latency; stall cycles push an invalid tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_r <= {SBOX_LAT{1'b0}};
            tag_grp_r <= {(4 * SBOX_LAT){1'b0}};
        end else if (flush) begin
            tag_vld_r <= {SBOX_LAT{1'b0}};
            tag_grp_r <= {(4 * SBOX_LAT){1'b0}};
        end else begin
            tag_vld_r[0] <= issue_s;
            tag_grp_r[0] <= grp_r;
            for (int i = 1; i < SBOX_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_grp_r[i] <= tag_grp_r[i-1];
            end
        end
    end

    // Result reassembly from the tagged lane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= 128'd0;
        end else if (!flush && tag_vld_r[SBOX_LAT-1]) begin
            result_r[cap_base_s +: LW] <= sbox_dout;
        end
    end

endmodule
